// File: rtl/wb_regfile.sv
// Write-back register file: 32 GPRs (r0 hardwired to zero), HI/LO pair and a retired-write
// counter. Reads are combinational with same-cycle bypass of the write being retired.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              whilo,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] wr_cnt
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] cnt_q;
  logic              wr_ok;

  // Writes to r0 are dropped entirely, so they neither land in storage nor count.
  assign wr_ok = we && (waddr != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_ok) begin
        regs[waddr] <= wdata;
        cnt_q       <= cnt_q + DATA_W'(1);
      end
      if (whilo) begin
        hi_q <= hi_i;
        lo_q <= lo_i;
      end
    end
  end

  // Bypass priority: disabled port / r0 first, then the in-flight write, then storage.
  assign rdata1 = (!rst || !re1 || raddr1 == '0) ? '0 :
                  (we && waddr == raddr1)        ? wdata : regs[raddr1];
  assign rdata2 = (!rst || !re2 || raddr2 == '0) ? '0 :
                  (we && waddr == raddr2)        ? wdata : regs[raddr2];

  assign hi_o   = !rst ? '0 : (whilo ? hi_i : hi_q);
  assign lo_o   = !rst ? '0 : (whilo ? lo_i : lo_q);
  assign wr_cnt = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized bench for wb_regfile against an array-based reference model; a narrow
// second instance exercises the write-counter wrap.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0, re1 = 1'b0, re2 = 1'b0, whilo = 1'b0;
  logic [4:0]  waddr = '0, raddr1 = '0, raddr2 = '0;
  logic [31:0] wdata = '0, hi_i = '0, lo_i = '0;
  logic [31:0] rdata1, rdata2, hi_o, lo_o, wr_cnt;

  logic        s_we = 1'b0, s_re1 = 1'b0, s_re2 = 1'b0, s_whilo = 1'b0;
  logic [1:0]  s_waddr = '0, s_raddr1 = '0, s_raddr2 = '0;
  logic [3:0]  s_wdata = '0, s_hi_i = '0, s_lo_i = '0;
  logic [3:0]  s_rdata1, s_rdata2, s_hi_o, s_lo_o, s_wr_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_hi, m_lo, m_cnt;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .whilo(whilo), .hi_i(hi_i), .lo_i(lo_i), .hi_o(hi_o), .lo_o(lo_o),
    .wr_cnt(wr_cnt)
  );

  wb_regfile #(.DATA_W(4), .ADDR_W(2), .NREGS(4)) dut_small (
    .clk(clk), .rst(rst), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
    .re1(s_re1), .raddr1(s_raddr1), .rdata1(s_rdata1),
    .re2(s_re2), .raddr2(s_raddr2), .rdata2(s_rdata2),
    .whilo(s_whilo), .hi_i(s_hi_i), .lo_i(s_lo_i), .hi_o(s_hi_o), .lo_o(s_lo_o),
    .wr_cnt(s_wr_cnt)
  );

  function automatic logic [31:0] m_read(input logic re, input logic [4:0] a);
    if (!rst || !re || a == 5'd0) return 32'd0;
    if (we && waddr == a) return wdata;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] m_hi_o();
    if (!rst) return 32'd0;
    return whilo ? hi_i : m_hi;
  endfunction

  function automatic logic [31:0] m_lo_o();
    if (!rst) return 32'd0;
    return whilo ? lo_i : m_lo;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_hi = 0; m_lo = 0; m_cnt = 0;
  endtask

  // Advance one clock: the model consumes the inputs present at the rising edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_clear();
    else begin
      if (we && waddr != 5'd0) begin
        m_regs[waddr] = wdata;
        m_cnt = m_cnt + 32'd1;
      end
      if (whilo) begin
        m_hi = hi_i;
        m_lo = lo_i;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    we = 0; re1 = 0; re2 = 0; whilo = 0;
    waddr = 0; raddr1 = 0; raddr2 = 0; wdata = 0; hi_i = 0; lo_i = 0;
  endtask

  task automatic test_reset();
    model_clear();
    rst = 0;
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      we = 1; waddr = 5'($urandom_range(1, 31)); wdata = $urandom;
      re1 = 1; raddr1 = waddr; re2 = 1; raddr2 = 5'($urandom);
      whilo = 1; hi_i = $urandom; lo_i = $urandom;
      #1;
      vectors++;
      if (rdata1 !== 0 || rdata2 !== 0 || hi_o !== 0 || lo_o !== 0 || wr_cnt !== 0) begin
        miscompares++;
        $display("FAIL reset_hold: rd1=%h rd2=%h hi=%h lo=%h cnt=%h required all 0",
                 rdata1, rdata2, hi_o, lo_o, wr_cnt);
      end
      tick();
    end
    idle();
    rst = 1;
    @(negedge clk);
    for (int r = 1; r < 32; r++) begin
      re1 = 1; raddr1 = 5'(r); re2 = 1; raddr2 = 5'(32 - r);
      #1;
      vectors++;
      if (rdata1 !== 0 || rdata2 !== 0 || hi_o !== 0 || lo_o !== 0 || wr_cnt !== 0) begin
        miscompares++;
        $display("FAIL reset_release r%0d: rd1=%h rd2=%h hi=%h lo=%h cnt=%h required all 0",
                 r, rdata1, rdata2, hi_o, lo_o, wr_cnt);
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    idle();
    we = 1; waddr = 5; wdata = 32'h1234_5678; re1 = 1; raddr1 = 5;
    #1;
    vectors++;
    if (rdata1 !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL bypass_r5: got %h required 12345678", rdata1);
    end
    tick();
    we = 0;
    #1;
    vectors++;
    if (rdata1 !== 32'h1234_5678 || wr_cnt !== m_cnt) begin
      miscompares++;
      $display("FAIL stored_r5: got %h cnt %h required 12345678 cnt %h", rdata1, wr_cnt, m_cnt);
    end
  endtask

  task automatic test_r0();
    logic [31:0] cnt_before;
    idle();
    cnt_before = m_cnt;
    we = 1; waddr = 0; wdata = 32'hDEAD_BEEF; re1 = 1; re2 = 1;
    #1;
    vectors++;
    if (rdata1 !== 0 || rdata2 !== 0) begin
      miscompares++;
      $display("FAIL r0_same: rd1=%h rd2=%h required 0", rdata1, rdata2);
    end
    tick();
    we = 0;
    #1;
    vectors++;
    if (rdata1 !== 0 || rdata2 !== 0 || wr_cnt !== cnt_before) begin
      miscompares++;
      $display("FAIL r0_next: rd1=%h rd2=%h cnt=%h required 0 0 %h",
               rdata1, rdata2, wr_cnt, cnt_before);
    end
  endtask

  task automatic test_port_enable();
    idle();
    we = 1; waddr = 7; wdata = 32'h0BAD_F00D;
    tick();
    idle();
    re1 = 1; raddr1 = 7; re2 = 0; raddr2 = 7;
    #1;
    vectors++;
    if (rdata1 !== 32'h0BAD_F00D || rdata2 !== 0) begin
      miscompares++;
      $display("FAIL re2_off: rd1=%h rd2=%h required 0badf00d 0", rdata1, rdata2);
    end
    we = 1; waddr = 7; wdata = 32'hA5A5_A5A5; re2 = 1;
    #1;
    vectors++;
    if (rdata1 !== 32'hA5A5_A5A5 || rdata2 !== 32'hA5A5_A5A5) begin
      miscompares++;
      $display("FAIL dual_bypass_r7: rd1=%h rd2=%h required a5a5a5a5 both", rdata1, rdata2);
    end
    tick();
  endtask

  task automatic test_hilo();
    logic [31:0] cnt_before;
    idle();
    cnt_before = m_cnt;
    whilo = 1; hi_i = 32'h1; lo_i = 32'h2; we = 1; waddr = 3; wdata = 32'h3333_0003;
    #1;
    vectors++;
    if (hi_o !== 32'h1 || lo_o !== 32'h2) begin
      miscompares++;
      $display("FAIL hilo_bypass: hi=%h lo=%h required 1 2", hi_o, lo_o);
    end
    tick();
    idle();
    re1 = 1; raddr1 = 3; hi_i = 32'hFFFF_FFFF; lo_i = 32'hFFFF_FFFF;
    #1;
    vectors++;
    if (hi_o !== 32'h1 || lo_o !== 32'h2 || rdata1 !== 32'h3333_0003 ||
        wr_cnt !== cnt_before + 32'd1) begin
      miscompares++;
      $display("FAIL hilo_stored: hi=%h lo=%h r3=%h cnt=%h required 1 2 33330003 %h",
               hi_o, lo_o, rdata1, wr_cnt, cnt_before + 32'd1);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      we = 1'($urandom); waddr = 5'($urandom); wdata = $urandom;
      re1 = ($urandom_range(0, 7) != 0); re2 = ($urandom_range(0, 7) != 0);
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom);
      whilo = ($urandom_range(0, 3) == 0); hi_i = $urandom; lo_i = $urandom;
      #1;
      vectors++;
      if (rdata1 !== m_read(re1, raddr1) || rdata2 !== m_read(re2, raddr2) ||
          hi_o !== m_hi_o() || lo_o !== m_lo_o() || wr_cnt !== m_cnt) begin
        miscompares++;
        $display("FAIL random c%0d: rd1=%h/%h rd2=%h/%h hi=%h/%h lo=%h/%h cnt=%h/%h (got/required)",
                 c, rdata1, m_read(re1, raddr1), rdata2, m_read(re2, raddr2),
                 hi_o, m_hi_o(), lo_o, m_lo_o(), wr_cnt, m_cnt);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_wrap();
    int n;
    s_we = 1; s_waddr = 2'd1;
    n = 0;
    while (n < 14) begin
      s_wdata = 4'(n);
      @(negedge clk);
      n++;
    end
    vectors++;
    if (s_wr_cnt !== 4'hE) begin
      miscompares++;
      $display("FAIL wrap_preload: cnt=%h required e", s_wr_cnt);
    end
    @(negedge clk);
    vectors++;
    if (s_wr_cnt !== 4'hF) begin
      miscompares++;
      $display("FAIL wrap_max: cnt=%h required f", s_wr_cnt);
    end
    @(negedge clk);
    s_we = 0;
    vectors++;
    if (s_wr_cnt !== 4'h0) begin
      miscompares++;
      $display("FAIL wrap_zero: cnt=%h required 0", s_wr_cnt);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    we = 1; waddr = 9; wdata = 32'h9999_0009; whilo = 1; hi_i = 32'h77; lo_i = 32'h88;
    #2;
    rst = 0;
    #1;
    re1 = 1; raddr1 = 9; re2 = 1; raddr2 = 5;
    #1;
    vectors++;
    if (rdata1 !== 0 || rdata2 !== 0 || hi_o !== 0 || lo_o !== 0 || wr_cnt !== 0) begin
      miscompares++;
      $display("FAIL reset_async: rd1=%h rd2=%h hi=%h lo=%h cnt=%h required all 0",
               rdata1, rdata2, hi_o, lo_o, wr_cnt);
    end
    tick();
    idle();
    rst = 1;
    re1 = 1; raddr1 = 9; re2 = 1; raddr2 = 5;
    #1;
    vectors++;
    if (rdata1 !== 0 || rdata2 !== 0 || hi_o !== 0 || lo_o !== 0 || wr_cnt !== 0) begin
      miscompares++;
      $display("FAIL reset_write_lost: r9=%h r5=%h hi=%h lo=%h cnt=%h required all 0",
               rdata1, rdata2, hi_o, lo_o, wr_cnt);
    end
    we = 1; waddr = 9; wdata = 32'h0000_1111;
    tick();
    idle();
    re1 = 1; raddr1 = 9;
    #1;
    vectors++;
    if (rdata1 !== 32'h0000_1111 || wr_cnt !== 32'd1) begin
      miscompares++;
      $display("FAIL post_reset_write: r9=%h cnt=%h required 00001111 1", rdata1, wr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_r0();
    test_port_enable();
    test_hilo();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
